robo_controller: RTL and testbench

Left-hand wall-following controller for the maze robot. Consumes the map block's sensor outputs (head, left, under, barrier) and produces its one-cycle movement commands (avancar, girar, remover), closing the robot/map loop on the shared selected_clock. Stops on the black target cell and flags faults for an unclearable barrier or a step budget overrun.

---
 rtl/robo_controller.sv | 104 ++++++++++
 tb/tb_robo_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/robo_controller.sv
// robo_controller: left-hand wall-following maze controller with target stop and fault detection
module robo_controller #(
    parameter int STEP_W     = 8,
    parameter int MAX_STEPS  = 200,
    parameter int MAX_REMOVE = 12
) (
    input  logic              selected_clock,
    input  logic              reset,
    input  logic              start,
    input  logic              head,
    input  logic              left,
    input  logic              under,
    input  logic              barrier,
    output logic              avancar,
    output logic              girar,
    output logic              remover,
    output logic              done,
    output logic              fault,
    output logic [STEP_W-1:0] step_count
);
    localparam int RW = $clog2(MAX_REMOVE + 1);

    typedef enum logic [2:0] {IDLE, DECIDE, CMD, TURN_R, REMOVE, DONE_S, FAULT_S} state_t;

    state_t        state;
    logic          jl;
    logic [1:0]    tcnt;
    logic [RW-1:0] rcnt;

    // Decision FSM; every command is registered and lasts exactly its command cycles
    always_ff @(posedge selected_clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            jl         <= 1'b0;
            tcnt       <= 2'd0;
            rcnt       <= '0;
            avancar    <= 1'b0;
            girar      <= 1'b0;
            remover    <= 1'b0;
            done       <= 1'b0;
            fault      <= 1'b0;
            step_count <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= DECIDE;
                DECIDE: begin
                    if (under) begin
                        state <= DONE_S;
                        done  <= 1'b1;
                    end else if (step_count >= STEP_W'(MAX_STEPS)) begin
                        state <= FAULT_S;
                        fault <= 1'b1;
                    end else if (barrier) begin
                        state   <= REMOVE;
                        remover <= 1'b1;
                        rcnt    <= RW'(1);
                        jl      <= 1'b0;
                    end else if (!left && !jl) begin
                        state <= CMD;
                        girar <= 1'b1;
                        jl    <= 1'b1;
                    end else if (!head) begin
                        state   <= CMD;
                        avancar <= 1'b1;
                        jl      <= 1'b0;
                        if (~&step_count) step_count <= step_count + STEP_W'(1);
                    end else begin
                        state <= TURN_R;
                        girar <= 1'b1;
                        tcnt  <= 2'd0;
                        jl    <= 1'b0;
                    end
                end
                CMD: begin
                    state   <= DECIDE;
                    avancar <= 1'b0;
                    girar   <= 1'b0;
                end
                TURN_R: begin
                    if (tcnt == 2'd2) begin
                        state <= DECIDE;
                        girar <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 2'd1;
                    end
                end
                REMOVE: begin
                    if (!barrier) begin
                        state   <= DECIDE;
                        remover <= 1'b0;
                    end else if (rcnt == RW'(MAX_REMOVE)) begin
                        state   <= FAULT_S;
                        remover <= 1'b0;
                        fault   <= 1'b1;
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                DONE_S, FAULT_S: state <= state;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_robo_controller.sv
// tb_robo_controller: vector, directed and randomized model-based checks of robo_controller
module tb_robo_controller;
    localparam int STEP_W = 8, MAX_STEPS = 200, MAX_REMOVE = 12;
    localparam logic [2:0] A = 3'b100, G = 3'b010, R = 3'b001, Z = 3'b000;

    logic selected_clock = 1'b0;
    logic reset, start, head, left, under, barrier;
    logic avancar, girar, remover, done, fault;
    logic [STEP_W-1:0] step_count;
    int tests = 0, failed = 0;

    robo_controller #(.STEP_W(STEP_W), .MAX_STEPS(MAX_STEPS), .MAX_REMOVE(MAX_REMOVE)) dut (
        .selected_clock(selected_clock), .reset(reset), .start(start), .head(head), .left(left),
        .under(under), .barrier(barrier), .avancar(avancar), .girar(girar), .remover(remover),
        .done(done), .fault(fault), .step_count(step_count)
    );

    always #5 selected_clock = ~selected_clock;

    typedef struct packed {
        logic head, left, under, barrier;
        logic [11:0] seq;
        logic dn;
    } vec_t;

    // behavioural model: action-level plan of upcoming command cycles
    int m_mode, m_steps, m_rem;
    logic m_jl, m_done, m_fault;
    logic [2:0] m_cmd;
    logic [2:0] pend[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; head = 1'b0; left = 1'b1; under = 1'b0; barrier = 1'b0;
        @(negedge selected_clock);
        @(negedge selected_clock);
        reset = 1'b0;
    endtask

    task automatic model_decide();
        if (under) begin
            m_done = 1'b1; m_mode = 2; m_cmd = Z;
        end else if (m_steps >= MAX_STEPS) begin
            m_fault = 1'b1; m_mode = 2; m_cmd = Z;
        end else if (barrier) begin
            m_jl = 1'b0; m_rem = 1; m_cmd = R;
        end else if (m_jl && !head) begin
            m_jl = 1'b0; m_cmd = A; pend.push_back(Z);
            if (m_steps < 255) m_steps++;
        end else if (!left && !m_jl) begin
            m_jl = 1'b1; m_cmd = G; pend.push_back(Z);
        end else if (!head) begin
            m_jl = 1'b0; m_cmd = A; pend.push_back(Z);
            if (m_steps < 255) m_steps++;
        end else begin
            m_jl = 1'b0; m_cmd = G;
            pend.push_back(G); pend.push_back(G); pend.push_back(Z);
        end
    endtask

    // advance the model across one clock edge using the inputs now applied
    task automatic model_step();
        if (m_mode == 0) begin
            if (start) m_mode = 1;
            m_cmd = Z;
        end else if (m_mode == 1) begin
            if (pend.size() > 0) m_cmd = pend.pop_front();
            else if (m_rem > 0) begin
                if (!barrier) begin
                    m_cmd = Z; m_rem = 0;
                end else if (m_rem == MAX_REMOVE) begin
                    m_cmd = Z; m_rem = 0; m_fault = 1'b1; m_mode = 2;
                end else begin
                    m_rem++; m_cmd = R;
                end
            end else model_decide();
        end else m_cmd = Z;
    endtask

    task automatic random_run(input int cycles, input int pb, input int pu);
        do_reset();
        m_mode = 0; m_steps = 0; m_rem = 0; m_jl = 1'b0; m_done = 1'b0; m_fault = 1'b0; m_cmd = Z;
        pend.delete();
        check("rnd_reset", 16'({avancar, girar, remover, done, fault, step_count}), 16'd0);
        for (int i = 0; i < cycles; i++) begin
            start   = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            head    = 1'($urandom_range(0, 1));
            left    = 1'($urandom_range(0, 1));
            barrier = (m_rem > 0) ? ($urandom_range(0, 7) < 7) : ($urandom_range(0, 99) < pb);
            under   = ($urandom_range(0, 999) < pu);
            model_step();
            @(negedge selected_clock);
            check($sformatf("rnd_cyc%0d", i), 16'({avancar, girar, remover, done, fault, step_count}),
                  16'({m_cmd, m_done, m_fault, 8'(m_steps)}));
        end
    endtask

    task automatic budget_run(input logic with_under);
        int n;
        do_reset();
        head = 1'b0; left = 1'b1; start = 1'b1;
        n = 0;
        while (step_count != 8'(MAX_STEPS) && n < 600) begin
            @(negedge selected_clock);
            n++;
        end
        check("budget_reach", 16'(step_count), 16'(MAX_STEPS));
        under = with_under;
        @(negedge selected_clock);
        check("budget_pre", 16'({done, fault}), 16'd0);
        @(negedge selected_clock);
        check(with_under ? "budget_under" : "budget_fault", 16'({done, fault}),
              with_under ? 16'b10 : 16'b01);
        repeat (3) @(negedge selected_clock);
        check("budget_frozen", 16'({avancar, girar, remover, step_count}), 16'({3'b000, 8'(MAX_STEPS)}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        int cnt;
        logic [7:0] pat;
        logic seen;
        vt[0] = {1'b0, 1'b1, 1'b0, 1'b0, {A, Z, A, Z}, 1'b0};
        vt[1] = {1'b1, 1'b1, 1'b0, 1'b0, {G, G, G, Z}, 1'b0};
        vt[2] = {1'b0, 1'b0, 1'b0, 1'b0, {G, Z, A, Z}, 1'b0};
        vt[3] = {1'b1, 1'b0, 1'b0, 1'b0, {G, Z, G, G}, 1'b0};
        vt[4] = {1'b0, 1'b1, 1'b1, 1'b0, {Z, Z, Z, Z}, 1'b1};
        vt[5] = {1'b0, 1'b1, 1'b0, 1'b1, {R, R, R, R}, 1'b0};
        vt[6] = {1'b0, 1'b1, 1'b1, 1'b1, {Z, Z, Z, Z}, 1'b1};

        do_reset();
        check("reset_state", 16'({avancar, girar, remover, done, fault, step_count}), 16'd0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            {head, left, under, barrier} = {vt[v].head, vt[v].left, vt[v].under, vt[v].barrier};
            start = 1'b1;
            @(negedge selected_clock);
            for (int k = 0; k < 4; k++) begin
                @(negedge selected_clock);
                check($sformatf("vec%0d_cyc%0d", v, k), 16'({avancar, girar, remover, done}),
                      16'({vt[v].seq[11-3*k -: 3], vt[v].dn}));
            end
        end

        do_reset();
        head = 1'b0; left = 1'b1; start = 1'b1; pat = 8'd0; seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge selected_clock);
            pat = {pat[6:0], avancar};
            seen = seen | girar | remover;
        end
        check("corridor_steps", 16'(step_count), 16'd4);
        check("corridor_pattern", 16'(pat), 16'b01010101);
        check("corridor_no_turn", 16'(seen), 16'd0);

        do_reset();
        head = 1'b0; left = 1'b1; barrier = 1'b1; start = 1'b1; cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge selected_clock);
            if (remover) cnt++;
            if (cnt == 9 && barrier) barrier = 1'b0;
            if (cnt > 0 && !remover) break;
        end
        check("barrier_cycles", 16'(cnt), 16'd9);
        check("barrier_decide", 16'({avancar, girar, remover, fault}), 16'd0);
        @(negedge selected_clock);
        check("barrier_forward", 16'({avancar, girar, remover, fault}), 16'b1000);

        do_reset();
        head = 1'b0; left = 1'b1; barrier = 1'b1; start = 1'b1; cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge selected_clock);
            if (remover) cnt++;
            if (cnt > 0 && !remover) break;
        end
        check("timeout_cycles", 16'(cnt), 16'(MAX_REMOVE));
        check("timeout_fault", 16'({avancar, girar, remover, done, fault}), 16'b00001);
        repeat (5) @(negedge selected_clock);
        check("timeout_sticky", 16'({avancar, girar, remover, done, fault}), 16'b00001);

        do_reset();
        head = 1'b1; left = 1'b1; start = 1'b1;
        for (int i = 0; i < 10 && !girar; i++) @(negedge selected_clock);
        @(posedge selected_clock);
        #1;
        check("turn_active", 16'(girar), 16'd1);
        reset = 1'b1;
        #1;
        check("async_reset", 16'({avancar, girar, remover, done, fault, step_count}), 16'd0);
        start = 1'b0;
        @(negedge selected_clock);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge selected_clock);
            seen = seen | avancar | girar | remover;
        end
        check("idle_wait", 16'(seen), 16'd0);
        start = 1'b1;
        @(negedge selected_clock);
        @(negedge selected_clock);
        check("restart_turn", 16'({avancar, girar, remover}), 16'({G}));

        budget_run(1'b0);
        budget_run(1'b1);

        random_run(300, 5, 2);
        random_run(300, 10, 1);
        random_run(300, 3, 3);
        random_run(1000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
